// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH operand bits, LSB first,
// with the ripple carry held in a flop and a registered sum/cout plus done pulse.

module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_a_q, sreg_a_d;
  logic [WIDTH-1:0]   sreg_b_q, sreg_b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               s_bit, c_bit;
  logic [WIDTH-1:0]   acc_shift;

  serial_fa_cell u_fa (
    .a_i (sreg_a_q[0]),
    .b_i (sreg_b_q[0]),
    .c_i (carry_q),
    .s_o (s_bit),
    .c_o (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_a_q <= '0;
      sreg_b_q <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_a_q <= sreg_a_d;
      sreg_b_q <= sreg_b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_a_d = sreg_a_q;
    sreg_b_d = sreg_b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at bit 0.
    acc_shift            = acc_q >> 1;
    acc_shift[WIDTH-1]   = s_bit;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_a_d = a;
          sreg_b_d = b;
          carry_d  = cin;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sreg_a_d = sreg_a_q >> 1;
        sreg_b_d = sreg_b_q >> 1;
        acc_d    = acc_shift;
        carry_d  = c_bit;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          sum_d   = acc_shift;
          cout_d  = c_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH = 8, 4 and 1.

module tb_serial_adder_ctrl;

  typedef struct {
    int          acc_cyc;
    logic [32:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_in, b_in;
  logic        cin_in;
  logic        start8, start4, start1;
  logic        busy8, done8, cout8;
  logic        busy4, done4, cout4;
  logic        busy1, done1, cout1;
  logic [7:0]  sum8;
  logic [3:0]  sum4;
  logic [0:0]  sum1;

  int          cyc;
  int          sel;
  int          n_chk;
  int          n_pass;
  exp_t        q[$];

  logic        obs_done, obs_busy;
  logic [32:0] obs_res;
  int          cur_w;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );
  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    obs_done = 1'b0;
    obs_busy = 1'b0;
    obs_res  = '0;
    cur_w    = 8;
    case (sel)
      0: begin obs_done = done8; obs_busy = busy8; obs_res = 33'({cout8, sum8}); cur_w = 8; end
      1: begin obs_done = done4; obs_busy = busy4; obs_res = 33'({cout4, sum4}); cur_w = 4; end
      default: begin obs_done = done1; obs_busy = busy1; obs_res = 33'({cout1, sum1}); cur_w = 1; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Output monitor: pops the scoreboard on done, checks latency, busy length and hold.
  initial begin
    logic [32:0] prev [3];
    int          busy_cnt;
    exp_t        e;
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) prev[i] = '0;
      end else begin
        if (obs_busy) busy_cnt++;
        if (obs_done) begin
          if (q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("result", 64'(obs_res), 64'(e.exp));
            check("latency", 64'(cyc - e.acc_cyc), 64'(cur_w));
          end
          check("busy_cycles", 64'(busy_cnt), 64'(cur_w));
          check("busy_with_done", 64'(obs_busy), 64'd0);
          busy_cnt = 0;
          prev[sel] = obs_res;
        end else begin
          check("hold", 64'(obs_res), 64'(prev[sel]));
        end
      end
    end
  end

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start8 = v;
      1: start4 = v;
      default: start1 = v;
    endcase
  endtask

  function automatic logic [32:0] model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                        input logic cc);
    logic [32:0] m, r;
    m = (33'd1 << w) - 33'd1;
    r = ({1'b0, aa} & m) + ({1'b0, bb} & m) + {32'd0, cc};
    return r & ((33'd1 << (w + 1)) - 33'd1);
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 64 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      check("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic run_op(input int s, input logic [31:0] aa, input logic [31:0] bb, input logic cc);
    exp_t e;
    int   w;
    w = (s == 0) ? 8 : (s == 1) ? 4 : 1;
    sel = s;
    @(negedge clk);
    a_in = aa; b_in = bb; cin_in = cc;
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    e.exp     = model(w, aa, bb, cc);
    q.push_back(e);
    set_start(s, 1'b0);
    wait_drain();
    @(posedge clk);
  endtask

  initial begin
    exp_t e;
    cyc = 0; sel = 0; n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_res8", 64'({cout8, sum8}), 64'd0);
    check("rst_res4", 64'({busy4, done4, cout4, sum4}), 64'd0);
    check("rst_res1", 64'({busy1, done1, cout1, sum1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=8 directed operands and a few random ones
    run_op(0, 32'h00, 32'h00, 1'b0);
    run_op(0, 32'hFF, 32'h01, 1'b0);
    run_op(0, 32'hA5, 32'h5A, 1'b1);
    run_op(0, 32'h3C, 32'h0F, 1'b0);
    run_op(0, 32'hFF, 32'hFF, 1'b1);
    for (int i = 0; i < 6; i++) run_op(0, $urandom, $urandom, 1'($urandom));

    // start held high: accepts every 10 edges, operands scrambled between accepts
    sel = 0;
    @(negedge clk);
    a_in = 32'h12; b_in = 32'h34; cin_in = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (k % 10 == 0) begin
        e.acc_cyc = cyc;
        e.exp     = 33'h046;
        q.push_back(e);
      end
      if ((k + 1) % 10 == 0) begin
        a_in = 32'h12; b_in = 32'h34; cin_in = 1'b0;
      end else begin
        a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
      end
    end
    start8 = 1'b0;
    wait_drain();

    // reset during RUN cycle 4 of an operation that must be discarded
    @(negedge clk);
    a_in = 32'h77; b_in = 32'h11; cin_in = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(sum8), 64'd0);
    check("abort_cout", 64'(cout8), 64'd0);
    check("abort_busy", 64'(busy8), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    run_op(0, 32'h12, 32'h34, 1'b0);

    // WIDTH=4 exhaustive
    for (int x = 0; x < 512; x++) run_op(1, 32'(x & 15), 32'((x >> 4) & 15), 1'(x >> 8));

    // WIDTH=1 exhaustive
    for (int x = 0; x < 8; x++) run_op(2, 32'(x & 1), 32'((x >> 1) & 1), 1'(x >> 2));
    run_op(2, 32'h1, 32'h1, 1'b1);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
